// File: rtl/fifo_pkg.sv
// Purpose : shared types and helpers for the fifo_flex FIFO and its bench.
// Contents: fifo_mode_e  - read mode select (STD registered read, FWFT show-ahead)
//           ptr_w()      - pointer width for a given depth (address bits + wrap bit)
package fifo_pkg;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  // One extra bit beyond the address lets full and empty be told apart
  // when the address bits of the two pointers are equal.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Purpose : producer/consumer-facing bus of fifo_flex.
// Signals : clr, wr_en, wdata, rd_en        - driven by the master (user side)
//           rdata, full_flag, empty_flag,
//           almost_full, almost_empty,
//           count, overflow, underflow      - driven by the slave (FIFO side)
// Modports: master (user), slave (FIFO).
interface fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);

  logic                      clr;
  logic                      wr_en;
  logic [WIDTH-1:0]          wdata;
  logic                      rd_en;
  logic [WIDTH-1:0]          rdata;
  logic                      full_flag;
  logic                      empty_flag;
  logic                      almost_full;
  logic                      almost_empty;
  logic [ptr_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output clr, wr_en, wdata, rd_en,
    input  rdata, full_flag, empty_flag, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wdata, rd_en,
    output rdata, full_flag, empty_flag, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Purpose : DEPTH x WIDTH storage array for fifo_flex.
// Ports   : clk      - write clock
//           we_i     - write enable
//           waddr_i  - write address
//           wdata_i  - write data
//           raddr_i  - read address (asynchronous read)
//           rdata_o  - contents at raddr_i
module fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; every slot is written before it can be
  // read, and leaving it unreset lets it map onto plain registers/LUT RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flex.sv
// Purpose : parametrised single-clock FIFO with STD or FWFT read mode,
//           occupancy count, almost flags, sticky errors and sync flush.
// Ports   : clk  - clock, all state on rising edge
//           rst  - asynchronous active-high reset
//           bus  - fifo_flex_if.slave (clr, wr_en, wdata, rd_en in;
//                  rdata, flags, count, overflow, underflow out)
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         DEPTH     = 8,
  parameter fifo_mode_e MODE      = STD,
  parameter int         AF_THRESH = DEPTH - 2,
  parameter int         AE_THRESH = 1
) (
  input logic       clk,
  input logic       rst,
  fifo_flex_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  // Elaboration-time legality checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_flex: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_flex: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_flex: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flex: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [PW-1:0]    count;
  logic             full, empty;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] ram_rdata;

  // Status decoded from the registered pointers only.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write to a full FIFO still goes through when a read frees a slot
  // on the same edge; the write lands in the slot being vacated.
  assign rd_acc = bus.rd_en & ~empty;
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // leaves it unassigned (which would infer a latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc)                 wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc)                 rd_ptr_d = rd_ptr_q + PW'(1);
      if (bus.wr_en && !wr_acc)   ovf_d    = 1'b1;
      if (bus.rd_en && !rd_acc)   udf_d    = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc & ~bus.clr),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  if (MODE == STD) begin : g_std
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)          rdata_q <= '0;
      else if (bus.clr) rdata_q <= '0;
      else if (rd_acc)  rdata_q <= ram_rdata;
    end
    assign bus.rdata = rdata_q;
  end else begin : g_fwft
    // Head entry shown directly; forced to zero so stale slots never leak.
    assign bus.rdata = empty ? '0 : ram_rdata;
  end

  assign bus.full_flag    = full;
  assign bus.empty_flag   = empty;
  assign bus.almost_full  = (count >= PW'(AF_THRESH));
  assign bus.almost_empty = (count <= PW'(AE_THRESH));
  assign bus.count        = count;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Purpose : directed self-checking bench for fifo_flex.
//           u_a: 32x8 STD, u_b: 32x8 FWFT, u_c: 8x4 STD (pointer wrap).
module tb_fifo_flex;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fifo_flex_if #(.WIDTH(32), .DEPTH(8)) ia ();
  fifo_flex_if #(.WIDTH(32), .DEPTH(8)) ib ();
  fifo_flex_if #(.WIDTH(8),  .DEPTH(4)) ic ();

  fifo_flex #(.WIDTH(32), .DEPTH(8), .MODE(STD))  u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  fifo_flex #(.WIDTH(32), .DEPTH(8), .MODE(FWFT)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  fifo_flex #(.WIDTH(8),  .DEPTH(4), .MODE(STD))  u_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    {ia.clr, ia.wr_en, ia.rd_en, ia.wdata} = '0;
    {ib.clr, ib.wr_en, ib.rd_en, ib.wdata} = '0;
    {ic.clr, ic.wr_en, ic.rd_en, ic.wdata} = '0;

    // ---- reset values
    #12;
    check("rst_count", ia.count, 0);
    check("rst_rdata", ia.rdata, 0);
    check("rst_empty", ia.empty_flag, 1);
    check("rst_full",  ia.full_flag, 0);
    check("rst_ae",    ia.almost_empty, 1);
    check("rst_af",    ia.almost_full, 0);
    check("rst_ovf",   ia.overflow, 0);
    check("rst_udf",   ia.underflow, 0);
    check("rst_fwft_rdata", ib.rdata, 0);
    rst = 1'b0;
    step();

    // ---- fill 0x11111111..0x88888888
    for (int i = 0; i < 8; i++) begin
      ia.wr_en = 1'b1;
      ia.wdata = 32'h1111_1111 * (i + 1);
      step();
      check($sformatf("fill_count[%0d]", i), ia.count, i + 1);
      check($sformatf("fill_af[%0d]", i), ia.almost_full, (i + 1) >= 6);
      check($sformatf("fill_ae[%0d]", i), ia.almost_empty, (i + 1) <= 1);
      check($sformatf("fill_full[%0d]", i), ia.full_flag, (i + 1) == 8);
    end

    // ---- write while full is rejected
    ia.wdata = 32'hBABA_BABA;
    step();
    ia.wr_en = 1'b0;
    check("ovf_set", ia.overflow, 1);
    check("ovf_count", ia.count, 8);
    step();
    check("ovf_sticky", ia.overflow, 1);

    // ---- drain, 1-cycle read latency
    for (int i = 0; i < 8; i++) begin
      ia.rd_en = 1'b1;
      step();
      check($sformatf("drain_data[%0d]", i), ia.rdata, 32'h1111_1111 * (i + 1));
      check($sformatf("drain_count[%0d]", i), ia.count, 7 - i);
      check($sformatf("drain_ae[%0d]", i), ia.almost_empty, (7 - i) <= 1);
    end
    ia.rd_en = 1'b0;
    check("drain_empty", ia.empty_flag, 1);
    step();
    check("rdata_hold", ia.rdata, 32'h8888_8888);

    // ---- read while empty is rejected, then flush
    ia.rd_en = 1'b1;
    step();
    ia.rd_en = 1'b0;
    check("udf_set", ia.underflow, 1);
    check("udf_rdata_hold", ia.rdata, 32'h8888_8888);
    check("udf_ovf_still", ia.overflow, 1);
    ia.clr = 1'b1;
    step();
    ia.clr = 1'b0;
    check("clr_ovf", ia.overflow, 0);
    check("clr_udf", ia.underflow, 0);
    check("clr_rdata", ia.rdata, 0);

    // ---- simultaneous read/write while full
    for (int i = 0; i < 8; i++) begin
      ia.wr_en = 1'b1;
      ia.wdata = 32'h1111_1111 * (i + 1);
      step();
    end
    ia.rd_en = 1'b1;
    ia.wdata = 32'hDEAD_BEEF;
    step();
    ia.wr_en = 1'b0;
    ia.rd_en = 1'b0;
    check("sim_full_count", ia.count, 8);
    check("sim_full_ovf", ia.overflow, 0);
    check("sim_full_rdata", ia.rdata, 32'h1111_1111);
    for (int i = 0; i < 8; i++) begin
      ia.rd_en = 1'b1;
      step();
      w = (i == 7) ? 32'hDEAD_BEEF : 32'h1111_1111 * (i + 2);
      check($sformatf("sim_drain[%0d]", i), ia.rdata, w);
    end
    ia.rd_en = 1'b0;
    check("sim_drain_empty", ia.empty_flag, 1);

    // ---- simultaneous read/write while empty
    ia.wr_en = 1'b1;
    ia.rd_en = 1'b1;
    ia.wdata = 32'hCAFE_0001;
    step();
    ia.wr_en = 1'b0;
    ia.rd_en = 1'b0;
    check("sim_empty_count", ia.count, 1);
    check("sim_empty_udf", ia.underflow, 1);
    check("sim_empty_rdata", ia.rdata, 32'hDEAD_BEEF);
    ia.clr = 1'b1;
    step();
    ia.clr = 1'b0;
    check("clr2_count", ia.count, 0);
    check("clr2_udf", ia.underflow, 0);

    // ---- reset mid-operation
    for (int i = 0; i < 3; i++) begin
      ia.wr_en = 1'b1;
      ia.wdata = 32'hA0 + i + 1;
      step();
    end
    ia.wr_en = 1'b0;
    ia.rd_en = 1'b1;
    step();
    ia.rd_en = 1'b0;
    check("pre_rst_rdata", ia.rdata, 32'hA1);
    check("pre_rst_count", ia.count, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count", ia.count, 0);
    check("mid_rst_rdata", ia.rdata, 0);
    check("mid_rst_empty", ia.empty_flag, 1);
    check("mid_rst_ae", ia.almost_empty, 1);
    #1 rst = 1'b0;
    step();
    ia.wr_en = 1'b1;
    ia.wdata = 32'h89AB_CDEF;
    step();
    ia.wr_en = 1'b0;
    ia.rd_en = 1'b1;
    step();
    ia.rd_en = 1'b0;
    check("post_rst_rdata", ia.rdata, 32'h89AB_CDEF);
    check("post_rst_empty", ia.empty_flag, 1);

    // ---- FWFT mode
    ib.wr_en = 1'b1;
    ib.wdata = 32'h7654_3210;
    step();
    ib.wr_en = 1'b0;
    check("fwft_rdata", ib.rdata, 32'h7654_3210);
    check("fwft_empty", ib.empty_flag, 0);
    ib.rd_en = 1'b1;
    step();
    ib.rd_en = 1'b0;
    check("fwft_pop_rdata", ib.rdata, 0);
    check("fwft_pop_empty", ib.empty_flag, 1);
    ib.wr_en = 1'b1;
    ib.wdata = 32'h0000_00C1;
    step();
    ib.wdata = 32'h0000_00C2;
    step();
    ib.wr_en = 1'b0;
    check("fwft_head1", ib.rdata, 32'hC1);
    ib.rd_en = 1'b1;
    step();
    ib.rd_en = 1'b0;
    check("fwft_head2", ib.rdata, 32'hC2);
    check("fwft_count", ib.count, 1);

    // ---- pointer wrap on a 4-deep FIFO
    for (int i = 0; i < 20; i++) begin
      ic.wr_en = 1'b1;
      ic.wdata = 8'(i + 3);
      step();
      ic.wr_en = 1'b0;
      check($sformatf("wrap_full_w[%0d]", i), ic.full_flag, 0);
      ic.rd_en = 1'b1;
      step();
      ic.rd_en = 1'b0;
      check($sformatf("wrap_data[%0d]", i), ic.rdata, 8'(i + 3));
      check($sformatf("wrap_empty[%0d]", i), ic.empty_flag, 1);
    end
    for (int i = 0; i < 4; i++) begin
      ic.wr_en = 1'b1;
      ic.wdata = 8'h40 + 8'(i);
      step();
      check($sformatf("wrap_fill_full[%0d]", i), ic.full_flag, i == 3);
    end
    ic.wr_en = 1'b0;
    check("wrap_fill_count", ic.count, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised single-clock FIFO; next generation of the team's 32x8 FIFO.
- Adds:
  - configurable width and depth;
  - standard or first-word-fall-through (FWFT) read mode;
  - occupancy count;
  - programmable almost-full/almost-empty flags;
  - sticky overflow/underflow errors;
  - synchronous flush.
- Sits between producer and consumer blocks in the same clock domain. Drop-in for the existing FIFO when MODE=STD.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- MODE, STD, read mode from fifo_pkg::fifo_mode_e (STD or FWFT).
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- wr_en  in  1  write request.
- wdata  in  WIDTH  write data.
- rd_en  in  1  read request (STD) / pop acknowledge (FWFT).
- rdata  out  WIDTH  read data.
- full_flag  out  1  count == DEPTH.
- empty_flag  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst=1, async):
  - wr_ptr and rd_ptr = 0, so count=0.
  - rdata=0, empty_flag=1, full_flag=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - count = wr_ptr - rd_ptr (modular).
  - full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- All flags and count are decoded combinationally from the registered pointers, so they are valid right after the edge that changes them.
- Accept rules, evaluated on the registered state before the edge:
  - rd_acc = rd_en & !empty_flag.
  - wr_acc = wr_en & (!full_flag | rd_acc). A write while full is accepted if a read is accepted in the same cycle.
  - When empty, a simultaneous wr_en and rd_en gives write accepted, read rejected, and underflow set.
- Sticky errors:
  - overflow is set on wr_en & !wr_acc.
  - underflow is set on rd_en & !rd_acc.
  - Both hold until clr or rst.
- clr has priority over wr_en and rd_en in the same cycle. On clr:
  - pointers -> 0, overflow/underflow -> 0;
  - rdata -> 0 in STD mode;
  - no write or read is performed that cycle.
- STD mode:
  - rdata is a register loaded with the head entry on rd_acc; visible the cycle after the rd_en edge (1-cycle latency).
  - rdata holds its value when there is no accepted read.
- FWFT mode:
  - rdata = empty_flag ? 0 : mem[rd_ptr], combinational from registered state.
  - A word written at edge N is on rdata after edge N.
  - rd_acc pops the head; the next entry appears after that edge.
- Simultaneous accepted read and write: count is unchanged. When full, the written slot is the one freed by the read.
- Reset asserted mid-operation: immediate return to reset values, regardless of clk.

Decomposition:
- fifo_pkg:
  - typedef enum fifo_mode_e {STD, FWFT};
  - function ptr_w(depth) returning $clog2(depth)+1.
  - Shared by fifo_flex and its bench.
- Sub-module fifo_ram:
  - DEPTH x WIDTH register array;
  - synchronous write port (we, waddr, wdata);
  - asynchronous read port (raddr -> rdata_int).
- fifo_flex holds pointers, accept logic, flags, sticky errors and the STD output register.
- Parameter legality (power-of-two DEPTH, threshold ranges) is checked with elaboration-time assertions.

Test Plan:
- Fill and drain: WIDTH=32, DEPTH=8, STD. Write 8 words 0x11111111..0x88888888, then read 8.
  - Data returns in order, one cycle after each rd_en.
  - count steps 0->8->0.
  - full_flag=1 after the 8th write; empty_flag=1 after the 8th read.
  - almost_full=1 from count 6; almost_empty=1 at count <=1.
- Overflow/underflow:
  - Write 0xBABABABA when full: rejected, overflow=1 and sticky, FIFO contents unchanged.
  - Read when empty: underflow=1. Pulse clr: both clear.
- Simultaneous at boundaries:
  - Full FIFO with wr_en=rd_en=1 and wdata=0xDEADBEEF: count stays 8, no overflow, 0xDEADBEEF is read out as the 8th word afterwards.
  - Empty FIFO with both high: count -> 1, underflow=1.
- FWFT mode: write 0x76543210 at edge N.
  - rdata=0x76543210 and empty_flag=0 right after edge N.
  - rd_en pop gives rdata=0, empty_flag=1.
- Reset mid-operation: write 3 words, assert rst between edges.
  - All outputs return to reset values immediately; count=0, rdata=0.
  - After release, writing 0x89ABCDEF then reading returns only 0x89ABCDEF.
- Pointer wrap: DEPTH=4, then 20 interleaved write/read pairs with incrementing data.
  - All data is returned in order; full_flag is never falsely asserted.
